// File: rtl/param_bus_processor.sv
// Multi-cycle processor moving every datapath transfer over one shared BUS; parametrised width/register count.
// Latency: mv/mvi/mvnz finish 1 cycle after the Run edge, ALU ops 3 cycles; Run is ignored while Busy.
module param_bus_processor #(
    parameter int DW  = 16,
    parameter int RAW = 3
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [DW-1:0] DIN,
    input  logic          Run,
    output logic          Done,
    output logic          Busy,
    output logic          Zero,
    output logic [DW-1:0] BUS
);
    localparam int IW   = 3 + 2 * RAW;
    localparam int NREG = 1 << RAW;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    logic [1:0]     step_q, step_d;
    logic [IW-1:0]  ir_q;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  g_q;
    logic [DW-1:0]  r_q [NREG];

    logic [2:0]     op;
    logic [RAW-1:0] rx, ry;
    logic           is_alu;
    logic           wr_en;
    logic [DW-1:0]  alu;

    assign op     = ir_q[IW-1 -: 3];
    assign rx     = ir_q[2*RAW-1 -: RAW];
    assign ry     = ir_q[RAW-1:0];
    assign is_alu = (op != OP_MV) && (op != OP_MVI) && (op != OP_MVNZ);

    generate
        if (DW > IW) begin : g_unused_din
            logic unused_din;
            assign unused_din = ^DIN[DW-1:IW];
        end
    endgenerate

    // Single bus source per step; zero whenever nothing drives it.
    always_comb begin
        BUS = '0;
        case (step_q)
            T1: begin
                if (op == OP_MVI)  BUS = DIN;
                else if (is_alu)   BUS = r_q[rx];
                else               BUS = r_q[ry];
            end
            T2:      BUS = r_q[ry];
            T3:      BUS = g_q;
            default: BUS = '0;
        endcase
    end

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = a_q + BUS;
            OP_SUB:  alu = a_q - BUS;
            OP_AND:  alu = a_q & BUS;
            OP_OR:   alu = a_q | BUS;
            OP_XOR:  alu = a_q ^ BUS;
            default: alu = '0;
        endcase
    end

    always_comb begin
        step_d = T0;
        case (step_q)
            T0:      step_d = Run ? T1 : T0;
            T1:      step_d = is_alu ? T2 : T0;
            T2:      step_d = T3;
            default: step_d = T0;
        endcase
    end

    assign Done  = ((step_q == T1) && !is_alu) || (step_q == T3);
    assign Busy  = (step_q != T0);
    assign Zero  = (g_q == '0);
    // mvnz still completes when G is zero, it just skips the write.
    assign wr_en = ((step_q == T1) && ((op == OP_MV) || (op == OP_MVI) ||
                                       ((op == OP_MVNZ) && (g_q != '0))))
                 || (step_q == T3);

    always_ff @(posedge clk) begin
        if (Reset) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            for (int i = 0; i < NREG; i++) r_q[i] <= '0;
        end else begin
            step_q <= step_d;
            if ((step_q == T0) && Run)    ir_q    <= DIN[IW-1:0];
            if ((step_q == T1) && is_alu) a_q     <= BUS;
            if (step_q == T2)             g_q     <= alu;
            if (wr_en)                    r_q[rx] <= BUS;
        end
    end
endmodule

// File: tb/tb_param_bus_processor.sv
// Scoreboarded bench for param_bus_processor: a 16-bit/8-register and an 8-bit/4-register instance.
module tb_param_bus_processor;
    logic        clk = 1'b0;
    logic        rst16, run16, done16, busy16, zero16;
    logic [15:0] din16, bus16;
    logic        rst8, run8, done8, busy8, zero8;
    logic [7:0]  din8, bus8;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    param_bus_processor #(.DW(16), .RAW(3)) dut16 (
        .clk(clk), .Reset(rst16), .DIN(din16), .Run(run16),
        .Done(done16), .Busy(busy16), .Zero(zero16), .BUS(bus16));

    param_bus_processor #(.DW(8), .RAW(2)) dut8 (
        .clk(clk), .Reset(rst8), .DIN(din8), .Run(run8),
        .Done(done8), .Busy(busy8), .Zero(zero8), .BUS(bus8));

    function automatic logic get_done(input bit sel);
        return sel ? done8 : done16;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy8 : busy16;
    endfunction
    function automatic logic get_zero(input bit sel);
        return sel ? zero8 : zero16;
    endfunction
    function automatic logic [15:0] get_bus(input bit sel);
        return sel ? {8'h00, bus8} : bus16;
    endfunction

    task automatic drive(input bit sel, input logic [15:0] d, input logic r);
        if (sel) begin din8 = d[7:0]; run8 = r; end
        else     begin din16 = d;     run16 = r; end
    endtask

    // Issue one instruction, push its expected BUS/latency, pop and compare at Done.
    task automatic issue(input bit sel, input string name, input logic [15:0] instr,
                         input logic [15:0] imm, input logic [15:0] exp, input int lat);
        int cyc;
        bit seen;
        logic [15:0] e;
        int el;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        drive(sel, instr, 1'b1);
        @(posedge clk); #1;
        drive(sel, imm, 1'b0);
        cyc = 1;
        seen = 0;
        while (!seen && cyc <= 6) begin
            @(negedge clk);
            if (get_done(sel)) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: no Done within %0d cycles", name, cyc - 1);
        end else begin
            if (get_bus(sel) !== e) begin
                errors++;
                $display("FAIL %s bus: got %h expected %h", name, get_bus(sel), e);
            end
            checks++;
            if (cyc !== el) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, cyc, el);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input bit sel, input string name, input logic exp);
        checks++;
        if (get_zero(sel) !== exp) begin
            errors++;
            $display("FAIL %s zero: got %b expected %b", name, get_zero(sel), exp);
        end
    endtask

    task automatic test_reset();
        rst16 = 1; rst8 = 1; run16 = 0; run8 = 0; din16 = '0; din8 = '0;
        repeat (2) @(posedge clk);
        #1; rst16 = 0; rst8 = 0;
        @(negedge clk);
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done16); end
        checks++; if (zero16 !== 1'b1) begin errors++; $display("FAIL reset zero: got %b expected 1", zero16); end
        checks++; if (bus16 !== 16'h0) begin errors++; $display("FAIL reset bus: got %h expected 0000", bus16); end
        checks++; if (zero8 !== 1'b1) begin errors++; $display("FAIL reset8 zero: got %b expected 1", zero8); end
        @(posedge clk); #1;
    endtask

    task automatic test_mvi_mv();
        issue(0, "mvi_r0", 16'h0040, 16'hAAAA, 16'hAAAA, 1);
        issue(0, "mv_r1_r0", 16'h0008, 16'h0, 16'hAAAA, 1);
    endtask

    task automatic test_add_sub();
        issue(0, "mvi_r0_5555", 16'h0040, 16'h5555, 16'h5555, 1);
        issue(0, "add_r0_r1", 16'h0081, 16'h0, 16'hFFFF, 3);
        issue(0, "sub_r0_r1", 16'h00C1, 16'h0, 16'h5555, 3);
        check_zero(0, "sub_nonzero", 1'b0);
    endtask

    task automatic test_wrap_mvnz();
        issue(0, "mvi_r0_ffff", 16'h0040, 16'hFFFF, 16'hFFFF, 1);
        issue(0, "mvi_r1_0001", 16'h0048, 16'h0001, 16'h0001, 1);
        issue(0, "add_wrap", 16'h0081, 16'h0, 16'h0000, 3);
        check_zero(0, "add_wrap", 1'b1);
        issue(0, "mvnz_g0", 16'h01D1, 16'h0, 16'h0001, 1);
        issue(0, "mv_r3_r2_nowrite", 16'h001A, 16'h0, 16'h0000, 1);
        issue(0, "mvi_r4", 16'h0060, 16'h1234, 16'h1234, 1);
        issue(0, "add_r4_r1", 16'h00A1, 16'h0, 16'h1235, 3);
        issue(0, "mvnz_gnz", 16'h01D1, 16'h0, 16'h0001, 1);
        issue(0, "mv_r3_r2_written", 16'h001A, 16'h0, 16'h0001, 1);
    endtask

    task automatic test_logic_ops();
        issue(0, "mvi_r5", 16'h0068, 16'h0F0F, 16'h0F0F, 1);
        issue(0, "mvi_r6", 16'h0070, 16'h00FF, 16'h00FF, 1);
        issue(0, "and_r5_r6", 16'h012E, 16'h0, 16'h000F, 3);
        issue(0, "mvi_r5_again", 16'h0068, 16'h0F0F, 16'h0F0F, 1);
        issue(0, "or_r5_r6", 16'h016E, 16'h0, 16'h0FFF, 3);
        issue(0, "xor_r5_r6", 16'h01AE, 16'h0, 16'h0F00, 3);
        issue(0, "mv_upper_bits_ignored", 16'hFE3E, 16'h0, 16'h00FF, 1);
    endtask

    // R0=0, R1=1 here; Run stays high through the whole add.
    task automatic test_run_held();
        int ndone;
        logic [15:0] e;
        logic exp_busy [4];
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_q.push_back(16'h0001);
        ndone = 0;
        din16 = 16'h0081; run16 = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy16 !== exp_busy[i]) begin
                errors++;
                $display("FAIL run_held busy[%0d]: got %b expected %b", i, busy16, exp_busy[i]);
            end
            if (done16 === 1'b1) begin
                ndone++;
                e = exp_q.pop_front();
                checks++;
                if (bus16 !== e) begin errors++; $display("FAIL run_held bus: got %h expected %h", bus16, e); end
            end
            if (i == 3) run16 = 0;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL run_held done_count: got %0d expected 1", ndone); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        din16 = 16'h00C1; run16 = 1;
        @(posedge clk); #1; run16 = 0;
        @(posedge clk); #1;
        rst16 = 1;
        @(posedge clk); #1; rst16 = 0;
        @(negedge clk);
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL mid_reset busy: got %b expected 0", busy16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL mid_reset done: got %b expected 0", done16); end
        checks++; if (bus16 !== 16'h0) begin errors++; $display("FAIL mid_reset bus: got %h expected 0000", bus16); end
        checks++; if (zero16 !== 1'b1) begin errors++; $display("FAIL mid_reset zero: got %b expected 1", zero16); end
        @(posedge clk); #1;
        issue(0, "mv_r0_r1_after_reset", 16'h0001, 16'h0, 16'h0000, 1);
        rst16 = 1; din16 = 16'h0040; run16 = 1;
        @(posedge clk); #1; rst16 = 0; run16 = 0;
        @(negedge clk);
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_over_run busy: got %b expected 0", busy16); end
        @(posedge clk); #1;
    endtask

    task automatic test_narrow();
        issue(1, "w8_mvi_r0", 16'h0010, 16'h00F0, 16'h00F0, 1);
        issue(1, "w8_mvi_r1", 16'h0014, 16'h0020, 16'h0020, 1);
        issue(1, "w8_add_wrap", 16'h0021, 16'h0, 16'h0010, 3);
        check_zero(1, "w8_add_wrap", 1'b0);
        issue(1, "w8_xor_self", 16'h0060, 16'h0, 16'h0000, 3);
        check_zero(1, "w8_xor_self", 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mvi_mv();
        test_add_sub();
        test_wrap_mvnz();
        test_logic_ops();
        test_run_held();
        test_reset_mid();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
